// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, decode codes and FSM states for the
// 7-segment scan capture path. Patterns are active-low, bit order g..a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] VAL_BLANK = 4'hF;
    localparam logic [3:0] VAL_BAD   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd: maps an active-low 7-bit segment pattern back to its
// digit value; blank reads as VAL_BLANK (ok), anything unknown as VAL_BAD.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       ok
);

    // Table lookup; unknown patterns fall through to the defaults.
    always_comb begin
        value = VAL_BAD;
        ok    = 1'b0;
        case (pattern)
            SEG_0:     begin value = 4'd0;      ok = 1'b1; end
            SEG_1:     begin value = 4'd1;      ok = 1'b1; end
            SEG_2:     begin value = 4'd2;      ok = 1'b1; end
            SEG_3:     begin value = 4'd3;      ok = 1'b1; end
            SEG_4:     begin value = 4'd4;      ok = 1'b1; end
            SEG_5:     begin value = 4'd5;      ok = 1'b1; end
            SEG_6:     begin value = 4'd6;      ok = 1'b1; end
            SEG_7:     begin value = 4'd7;      ok = 1'b1; end
            SEG_8:     begin value = 4'd8;      ok = 1'b1; end
            SEG_9:     begin value = 4'd9;      ok = 1'b1; end
            SEG_BLANK: begin value = VAL_BLANK; ok = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: monitors a multiplexed active-low 7-segment bus, captures
// each digit once its pattern has been stable for STABLE_CYCLES synchronized
// samples, assembles scan frames and flags multiple-anode faults.
// Optional: define SEG7_DP_CAPTURE_EN to add dp_val and make dp part of the
// stability comparison.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_valid,
    output logic                    frame_done,
    output logic                    err_multi_an
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]   dp_val
`endif
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTW = 8;

    logic [7:0]            seg_q1, s_seg;
    logic [NUM_DIGITS-1:0] an_q1, s_an;
    logic [NUM_DIGITS-1:0] active;
    logic                  one_hot, multi, multi_q;
    logic [IDXW-1:0]       idx_new, idx_q, idx_d;
    logic [7:0]            lat_seg_q, lat_seg_d;
    logic [NUM_DIGITS-1:0] lat_an_q, lat_an_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    scan_state_t           state_q, state_d;
    logic                  seg_diff, an_diff, cap;
    logic [NUM_DIGITS-1:0] cap_bits, frame_mask;
    logic                  mask_full;
    logic [3:0]            dec_val;
    logic                  dec_ok;

    // Two-flop synchronizers; idle bus (all ones) is the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q1 <= '1;
            s_seg  <= '1;
            an_q1  <= '1;
            s_an   <= '1;
        end else begin
            seg_q1 <= seg_in;
            s_seg  <= seg_q1;
            an_q1  <= an_in;
            s_an   <= an_q1;
        end
    end

    assign active    = ~s_an;
    assign one_hot   = $onehot(active);
    assign multi     = ($countones(active) > 1);
    assign an_diff   = (s_an != lat_an_q);
    assign mask_full = &frame_mask;

    // err pulses only on the transition into a multi-anode condition.
    assign err_multi_an = multi & ~multi_q;

`ifdef SEG7_DP_CAPTURE_EN
    assign seg_diff = (s_seg != lat_seg_q);
`else
    assign seg_diff = (s_seg[6:0] != lat_seg_q[6:0]);
    // dp is ignored in this build.
    logic unused_dp;
    assign unused_dp = s_seg[7] ^ lat_seg_q[7];
`endif

    // Index of the single active anode.
    always_comb begin
        idx_new = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (active[i]) idx_new = IDXW'(i);
        end
    end

    // Next-state: IDLE/HOLD re-evaluate on any change, TRACK counts stable samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lat_seg_d = lat_seg_q;
        lat_an_d  = lat_an_q;
        cap       = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    state_d   = TRACK;
                    cnt_d     = CNTW'(1);
                    idx_d     = idx_new;
                    lat_seg_d = s_seg;
                    lat_an_d  = s_an;
                end
            end
            TRACK, HOLD: begin
                if (seg_diff || an_diff) begin
                    if (one_hot) begin
                        state_d   = TRACK;
                        cnt_d     = CNTW'(1);
                        idx_d     = idx_new;
                        lat_seg_d = s_seg;
                        lat_an_d  = s_an;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == TRACK) begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(STABLE_CYCLES - 1)) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot mask bit for the digit being captured this cycle.
    always_comb begin
        cap_bits = '0;
        if (cap) cap_bits[idx_q] = 1'b1;
    end

    // FSM and tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            lat_seg_q <= '1;
            lat_an_q  <= '1;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lat_seg_q <= lat_seg_d;
            lat_an_q  <= lat_an_d;
            multi_q   <= multi;
        end
    end

    seg7_pattern_to_bcd u_dec (
        .pattern (lat_seg_q[6:0]),
        .value   (dec_val),
        .ok      (dec_ok)
    );

    // Capture writes and frame bookkeeping; a capture in the clearing cycle survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_val   <= '1;
            digit_ok    <= '0;
            frame_mask  <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_val      <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap && (idx_q == IDXW'(i))) begin
                    digit_val[4*i +: 4] <= dec_val;
                    digit_ok[i]         <= dec_ok;
`ifdef SEG7_DP_CAPTURE_EN
                    dp_val[i]           <= ~lat_seg_q[7];
`endif
                end
            end
            frame_done <= mask_full;
            if (mask_full) frame_valid <= 1'b1;
            frame_mask <= (mask_full ? '0 : frame_mask) | cap_bits;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench; stimulus pushes expected capture,
// frame and error events with their cycle stamps, a monitor pops and compares.
module tb_seg7_scan_capture;

`ifdef SEG7_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    localparam int K_CAP = 0;
    localparam int K_FRM = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        int         idx;
        logic [3:0] val;
        logic       ok;
        logic       dp;
        int         cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] digit_val;
    logic [3:0]  digit_ok;
    logic        frame_valid, frame_done, err_multi_an;
    logic [3:0]  dp_obs;

    int  cyc = 0;
    int  t0 = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    seg7_scan_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .an_in        (an_in),
        .digit_val    (digit_val),
        .digit_ok     (digit_ok),
        .frame_valid  (frame_valid),
        .frame_done   (frame_done),
        .err_multi_an (err_multi_an)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .dp_val       (dp_obs)
`endif
    );

`ifndef SEG7_DP_CAPTURE_EN
    assign dp_obs = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_dp(input logic [7:0] seg);
        return DP_EN & ~seg[7];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int idx, input logic [3:0] val,
                        input logic ok, input logic dp, input int at);
        ev_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.ok = ok; e.dp = dp; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int idx, input logic [3:0] val,
                           input logic ok, input logic dp);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual kind=%0d idx=%0d val=%h ok=%b dp=%b cyc=%0d required none",
                     kind, idx, val, ok, dp, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.val !== val || e.ok !== ok ||
                e.dp !== dp || e.cyc != cyc) begin
                failures++;
                $display("FAIL event actual kind=%0d idx=%0d val=%h ok=%b dp=%b cyc=%0d required kind=%0d idx=%0d val=%h ok=%b dp=%b cyc=%0d",
                         kind, idx, val, ok, dp, cyc, e.kind, e.idx, e.val, e.ok, e.dp, e.cyc);
            end
        end
    endtask

    // Monitor: turns output changes and pulses into events for the scoreboard.
    initial begin
        logic [15:0] pv;
        logic [3:0]  pok, pdp;
        pv = '1; pok = '0; pdp = '0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (digit_val[4*i +: 4] !== pv[4*i +: 4] || digit_ok[i] !== pok[i] ||
                        dp_obs[i] !== pdp[i])
                        observe(K_CAP, i, digit_val[4*i +: 4], digit_ok[i], dp_obs[i]);
                end
                if (frame_done)   observe(K_FRM, 0, 4'h0, 1'b0, 1'b0);
                if (err_multi_an) observe(K_ERR, 0, 4'h0, 1'b0, 1'b0);
            end
            pv = digit_val; pok = digit_ok; pdp = dp_obs;
        end
    end

    task automatic go(input logic [3:0] an, input logic [7:0] seg);
        @(posedge clk);
        #1;
        an_in  = an;
        seg_in = seg;
        t0     = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Capture on digit idx expected 2 sync + 8 stable cycles after the change.
    task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int idx,
                         input logic [3:0] val, input logic ok, input bit frame);
        go(an, seg);
        push(K_CAP, idx, val, ok, exp_dp(seg), t0 + 10);
        if (frame) push(K_FRM, 0, 4'h0, 1'b0, 1'b0, t0 + 11);
        idle(20);
    endtask

    initial begin
        // Power-on reset values
        idle(3);
        #1;
        chk("rst_digit_val", 32'(digit_val), 32'hFFFF);
        chk("rst_digit_ok", 32'(digit_ok), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;

        // Single digit: value 1 on digit 0, 12-cycle dwell
        go(4'b1110, 8'hF9);
        push(K_CAP, 0, 4'h1, 1'b1, exp_dp(8'hF9), t0 + 10);
        idle(12);
        chk("single_digit_val", 32'(digit_val), 32'hFFF1);
        chk("single_digit_ok", 32'(digit_ok), 32'h1);
        go(4'b1111, 8'hFF);
        idle(4);

        // Full scan with an overwrite on digit 0 that must not end the frame early
        do_reset();
        dwell(4'b1110, 8'hF8, 0, 4'h7, 1'b1, 1'b0);
        dwell(4'b1110, 8'hF9, 0, 4'h1, 1'b1, 1'b0);
        dwell(4'b1101, 8'hA4, 1, 4'h2, 1'b1, 1'b0);
        dwell(4'b1011, 8'hB0, 2, 4'h3, 1'b1, 1'b0);
        dwell(4'b0111, 8'h99, 3, 4'h4, 1'b1, 1'b1);
        chk("scan_digit_val", 32'(digit_val), 32'h4321);
        chk("scan_frame_valid", 32'(frame_valid), 32'h1);
        // Mask was cleared: three digits alone give no frame, the fourth does
        dwell(4'b1110, 8'h92, 0, 4'h5, 1'b1, 1'b0);
        dwell(4'b1101, 8'h82, 1, 4'h6, 1'b1, 1'b0);
        dwell(4'b1011, 8'hF8, 2, 4'h7, 1'b1, 1'b0);
        dwell(4'b0111, 8'h80, 3, 4'h8, 1'b1, 1'b1);
        chk("scan2_digit_val", 32'(digit_val), 32'h8765);

        // Glitch: short 2-pattern between stable 0 dwells on digit 0
        do_reset();
        dwell(4'b1110, 8'hC0, 0, 4'h0, 1'b1, 1'b0);
        go(4'b1110, 8'hA4);
        idle(4);
        go(4'b1110, 8'hC0);
        idle(20);
        chk("glitch_digit_val", 32'(digit_val), 32'hFFF0);

        // Multi-anode: single error pulse, no capture
        go(4'b1100, 8'hF9);
        push(K_ERR, 0, 4'h0, 1'b0, 1'b0, t0 + 2);
        idle(20);
        chk("multi_digit_val", 32'(digit_val), 32'hFFF0);
        go(4'b1111, 8'hFF);
        idle(5);

        // Bad pattern on digit 2, then a good 0 with dp lit
        dwell(4'b1011, 8'h55, 2, 4'hE, 1'b0, 1'b0);
        chk("bad_digit_ok", 32'(digit_ok), 32'h1);
        dwell(4'b1011, 8'h40, 2, 4'h0, 1'b1, 1'b0);
        chk("good_digit_val", 32'(digit_val), 32'hF0F0);
        chk("good_dp_val", 32'(dp_obs), DP_EN ? 32'h4 : 32'h0);

        // Reset mid-TRACK: async clear, then count restarts from the release
        go(4'b0111, 8'h99);
        idle(5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_digit_val", 32'(digit_val), 32'hFFFF);
        chk("midrst_digit_ok", 32'(digit_ok), 32'h0);
        chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
        chk("midrst_frame_done", 32'(frame_done), 32'h0);
        chk("midrst_err", 32'(err_multi_an), 32'h0);
        chk("midrst_dp_val", 32'(dp_obs), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
        push(K_CAP, 3, 4'h4, 1'b1, exp_dp(8'h99), t0 + 10);
        idle(15);

        idle(5);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event actual none required kind=%0d idx=%0d val=%h cyc=%0d",
                     e.kind, e.idx, e.val, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Monitor on the multiplexed 7-segment display bus. It is the reading end of the BCD-to-segment decoder path.
- Samples active-low segment and anode lines, waits for each digit's pattern to be stable, and converts it back to a 4-bit value.
- Assembles a full scan frame of digit values and flags protocol errors.
- Used for board self-test and for closed-loop checks of the traffic-light display.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode lines).
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before a capture; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- seg_in  in  8  segment lines, active-low; bit7 = dp, bits6..0 = g..a.
- an_in  in  NUM_DIGITS  anode selects, active-low; bit i = digit i.
- digit_val  out  4*NUM_DIGITS  captured values; nibble i = digit i.
- digit_ok  out  NUM_DIGITS  1 = last capture of digit i was a recognised pattern.
- frame_valid  out  1  sticky; 1 once at least one complete frame has been captured.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous frame.
- err_multi_an  out  1  one-cycle pulse when more than one anode becomes active.

Behaviour:
- Reset, asynchronous on rst high:
  - digit_val = all 0xF; digit_ok = 0; frame_valid = 0; frame_done = 0; err_multi_an = 0.
  - Frame mask = 0; stability counter = 0; state = IDLE; synchronizers = all ones.
- Input synchronization: seg_in and an_in pass through 2-flop synchronizers. All logic below runs on the synchronized copies (s_seg, s_an).
- Pattern decode (combinational, bits6..0 only; dp ignored):
  - Digits 0..9 map to the team segment table: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x18→9.
  - 0x7F (blank) → value 0xF with ok = 1.
  - Any other pattern → value 0xE with ok = 0.
- FSM states:
  - IDLE: s_an has zero or several active bits.
    - On exactly one active bit: load counter = 1, latch the digit index and s_seg, go to TRACK.
  - TRACK: exactly one anode is active and unchanged, and s_seg equals the latched value.
    - Each cycle, counter increments.
    - When counter reaches STABLE_CYCLES: write the decoded value and ok into the digit slot, set that bit in the frame mask, go to HOLD.
    - If s_seg or s_an changes: restart TRACK with counter = 1 and the new values, or go to IDLE if the anode count is not exactly one.
  - HOLD: waits for any change of s_seg or s_an, then re-evaluates as IDLE does in that same cycle. A digit is captured at most once per dwell.
- Multi-anode: err_multi_an pulses in the cycle s_an goes from ≤1 active bit to ≥2 active bits. FSM goes to IDLE. No capture occurs.
- Frame completion:
  - In the cycle after the frame mask becomes all ones: frame_done pulses, frame_valid sets, and the mask clears.
  - A capture that lands in the clearing cycle is kept in the new mask.
- Latency: pin change → capture write takes 2 sync cycles + STABLE_CYCLES. The write → frame_done pulse takes +1 cycle.
- Recapturing a digit already set in the mask overwrites its value; it does not complete the frame early.
- rst asserted mid-TRACK discards the partial count immediately.

Optional Feature:
- Macro SEG7_DP_CAPTURE_EN.
- When defined: an extra output dp_val [NUM_DIGITS-1:0], reset 0. It captures ~s_seg[7] into bit i at the same instant as digit i's value write. The dp bit also takes part in the stability comparison.
- When undefined: no port, and dp changes are ignored by the stability check.

Decomposition:
- Package seg7_pkg holds:
  - Pattern constants SEG_0..SEG_9 and SEG_BLANK (7-bit, active-low).
  - Decode codes VAL_BLANK = 0xF and VAL_BAD = 0xE.
  - FSM enum {IDLE, TRACK, HOLD}.
- One sub-module, seg7_pattern_to_bcd: combinational 7-bit pattern → {value[3:0], ok}. It is instantiated once on the latched pattern.

Test Plan:
- Reset check: assert rst mid-run → all outputs at reset values in the same cycle, before the next clk edge.
- Single digit: an_in = 1110, seg_in = 0xF9 held 12 cycles → digit_val[3:0] = 1 and digit_ok[0] = 1 exactly 2+8 cycles after the change; other nibbles stay 0xF.
- Full scan: digits 0..3 show 1,2,3,4, 20 cycles each → digit_val = 0x4321, one frame_done pulse, frame_valid = 1, mask cleared.
- Glitch: 5-cycle 0xA4 on digit 0 between stable 0xC0 dwells → digit 0 is never written with 2 and ends at 0.
- Multi-anode: an_in = 1100 for 20 cycles → a single err_multi_an pulse, no digit_val change, no frame_done.
- Bad pattern: seg_in = 0x55 held on digit 2 → nibble 2 = 0xE and digit_ok[2] = 0. Under SEG7_DP_CAPTURE_EN, seg_in = 0x40 → dp_val[2] = 1 and value 0.
